fp_add_p2: RTL and testbench
============================

// Module: fp_add_p2
// PURPOSE
//  Second and final stage of the FP32 adder/subtractor. Consumes the aligned mantissas,
//  common exponent and signs from the alignment stage and adds or subtracts the magnitudes.
//  Normalises the result (carry shift or leading-zero shift) and packs it into IEEE-754
//  single precision with status flags. Two-deep pipeline with valid/ready on both sides.
//  Feeds the FPU writeback mux.
// PARAMETERS
//  MANT_W  24  aligned mantissa width including the hidden bit (fixed to FP32; not for override)
//  EXP_W   8   exponent width
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous reset, active low
//  in_valid   in   1   upstream operands valid
//  in_ready   out  1   stage 1 can accept
//  mant_a     in   24  aligned mantissa A (hidden bit included)
//  mant_b     in   24  aligned mantissa B
//  exp_large  in   8   common (larger) biased exponent
//  sign_a     in   1   sign of A
//  sign_b     in   1   effective sign of B (already inverted for subtract)
//  out_valid  out  1   result valid
//  out_ready  in   1   downstream accepts
//  result     out  32  packed FP32 result
//  flag_ovf   out  1   overflow: result forced to +/-inf
//  flag_unf   out  1   underflow: result flushed to signed zero
//  flag_zero  out  1   exact-zero result
// BEHAVIOUR
//  - Reset (async, rst_n=0): s1_valid=0, out_valid=0, result=0, all flags=0. in_ready=1 after
//    the reset is released. Any in-flight data is discarded.
//  - Handshakes: transfer on valid&&ready. out_valid, result and flags hold stable while
//    out_valid&&!out_ready.
//  - Stall rules: out_adv = !out_valid || out_ready. in_ready = !s1_valid || out_adv, which is
//    combinational from out_ready (no bubble penalty). Capacity is 2 entries.
//  - Latency: 2 cycles from the input transfer to out_valid with no stall. Order is preserved.
//  - Stage 1 (add/sub), registered when in_valid && in_ready:
//      eff_sub = sign_a ^ sign_b
//      add: sum[24:0] = mant_a + mant_b; sign = sign_a
//      sub: if mant_a >= mant_b then sum = mant_a - mant_b, sign = sign_a;
//           else sum = mant_b - mant_a, sign = sign_b
//      Latch exp_large. Use a 25-bit sum with no truncation.
//  - Stage 2 (normalise and pack), registered when s1_valid && out_adv:
//      sum==0                -> result={1'b0,31'b0} (+0), flag_zero=1
//      sum[24]==1            -> mant=sum[23:1], exp=exp_large+1 (9-bit arithmetic)
//      else lz=lzc(sum[23:0]) -> mant=(sum<<lz)[22:0], exp=exp_large-lz (signed 10-bit)
//      exp >= 255            -> {sign,8'hFF,23'b0}, flag_ovf=1
//      exp <= 0              -> {sign,31'b0}, flag_unf=1 (flush; no subnormals)
//      otherwise             -> {sign,exp[7:0],mant}
//  - Rounding: truncate (round toward zero). Bits shifted out on carry normalisation are dropped.
//  - Inputs with exp_large==0 and mant==0 (the upstream reset/NaN-kill pattern) produce +0 with
//    flag_zero=1. No NaN generation.
//  - The flags are mutually exclusive and valid only with out_valid.
//  - Simultaneous output accept and new input: both stages advance in the same cycle; no loss,
//    no duplication.
// STRUCTURE
//  - fp_pkg: FP32_EXP_MAX=8'hFF, FP32_POS_ZERO, FP32_INF_MAG, the fp_flags_t struct
//    {ovf, unf, zero}, and the MANT_W/EXP_W constants.
//  - Sub-module fp_lzc24: combinational 24-bit leading-zero counter, 5-bit count,
//    returns 24 for an all-zero input.
//  - Top level: stage-1 register and adder, stage-2 normalise/pack register, stall logic.
// TESTING
//  1. 1.0+1.0: mant_a=mant_b=24'h800000, exp=127, signs 0
//     -> result=32'h40000000 two cycles after the transfer, no flags.
//  2. 1.0-1.0: same operands, sign_b=1 -> result=32'h00000000, flag_zero=1.
//  3. 1.0-1.5: mant_a=24'h800000, mant_b=24'hC00000, exp=127, sign_b=1
//     -> diff 24'h400000, lz=1, result=32'hBF000000 (-0.5).
//  4. Overflow: exp=254, mant_a=mant_b=24'h800000, add -> 32'h7F800000, flag_ovf=1.
//     Underflow: exp=1, 24'h800000-24'h7FFFFF -> lz=23, exp<=0 -> 32'h00000000, flag_unf=1.
//  5. Backpressure: hold out_ready=0 and offer 3 back-to-back ops
//     -> in_ready drops after 2 are accepted, output stays stable; after release all 3 emerge
//     in order and none are lost.
//  6. Assert rst_n low while 2 ops are in flight
//     -> out_valid=0 and result=0 immediately (asynchronous); after release no stale result appears.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared FP32 constants and status-flag type for the adder pipeline
package fp_pkg;
    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam logic [EXP_W-1:0] FP32_EXP_MAX  = 8'hFF;
    localparam logic [31:0]      FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [30:0]      FP32_INF_MAG  = {FP32_EXP_MAX, 23'b0};
    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero;
    } fp_flags_t;
endpackage

// File: rtl/fp_lzc24.sv
// fp_lzc24: combinational leading-zero counter, returns 24 for an all-zero input
module fp_lzc24 (
    input  logic [23:0] a_i,
    output logic [4:0]  cnt_o
);
    always_comb begin
        cnt_o = 5'd24;
        for (int i = 0; i < 24; i++)
            if (a_i[i]) cnt_o = 5'(23 - i);
    end
endmodule

// File: rtl/fp_add_p2.sv
// fp_add_p2: FP32 add/sub final stage - magnitude add, normalise, pack with flags
// Two registered stages with valid/ready; truncating rounding, flush-to-zero underflow.
module fp_add_p2
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] mant_a,
    input  logic [MANT_W-1:0] mant_b,
    input  logic [EXP_W-1:0]  exp_large,
    input  logic              sign_a,
    input  logic              sign_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       result,
    output logic              flag_ovf,
    output logic              flag_unf,
    output logic              flag_zero
);
    logic              s1_valid_q, out_valid_q;
    logic [MANT_W:0]   s1_sum_q, s1_sum_d;
    logic              s1_sign_q, s1_sign_d;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [31:0]       result_q, result_d;
    fp_flags_t         flags_q, flags_d;
    logic              out_adv, eff_sub, a_ge_b, is_zero, ovf, unf;
    logic [4:0]        lz;
    logic [22:0]       norm_sh, mant;
    logic signed [9:0] exp_n;

    assign out_adv  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || out_adv;

    always_comb begin
        eff_sub   = sign_a ^ sign_b;
        a_ge_b    = mant_a >= mant_b;
        s1_sum_d  = !eff_sub ? {1'b0, mant_a} + {1'b0, mant_b} :
                    a_ge_b   ? {1'b0, mant_a - mant_b} : {1'b0, mant_b - mant_a};
        s1_sign_d = (eff_sub && !a_ge_b) ? sign_b : sign_a;
    end

    fp_lzc24 u_lzc (.a_i(s1_sum_q[23:0]), .cnt_o(lz));

    // Carry: shift right once and bump the exponent; otherwise shift left by lz.
    always_comb begin
        norm_sh  = 23'(s1_sum_q[23:0] << lz);
        mant     = s1_sum_q[24] ? s1_sum_q[23:1] : norm_sh;
        exp_n    = s1_sum_q[24] ? $signed({2'b0, s1_exp_q}) + 10'sd1
                                : $signed({2'b0, s1_exp_q}) - $signed({5'b0, lz});
        is_zero  = s1_sum_q == '0;
        ovf      = !is_zero && exp_n >= 10'sd255;
        unf      = !is_zero && exp_n <= 10'sd0;
        flags_d  = {ovf, unf, is_zero};
        result_d = is_zero ? FP32_POS_ZERO :
                   ovf     ? {s1_sign_q, FP32_INF_MAG} :
                   unf     ? {s1_sign_q, 31'b0} : {s1_sign_q, exp_n[7:0], mant};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            if (in_ready) s1_valid_q <= in_valid;
            if (in_valid && in_ready) begin
                s1_sum_q  <= s1_sum_d;
                s1_sign_q <= s1_sign_d;
                s1_exp_q  <= exp_large;
            end
            if (out_adv) out_valid_q <= s1_valid_q;
            if (s1_valid_q && out_adv) begin
                result_q <= result_d;
                flags_q  <= flags_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_ovf  = flags_q.ovf;
    assign flag_unf  = flags_q.unf;
    assign flag_zero = flags_q.zero;
endmodule

// File: tb/tb_fp_add_p2.sv
// tb_fp_add_p2: scoreboard bench for fp_add_p2 against an arithmetic reference model
module tb_fp_add_p2;
    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic        sign_a, sign_b, flag_ovf, flag_unf, flag_zero;
    logic [23:0] mant_a, mant_b;
    logic [7:0]  exp_large;
    logic [31:0] result;

    int checks = 0, errors = 0, accepted = 0;
    bit rand_rdy = 0, prev_stall = 0;
    logic [34:0] exp_q[$];
    logic [34:0] prev_out, mon_e;

    fp_add_p2 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mant_a(mant_a), .mant_b(mant_b), .exp_large(exp_large),
        .sign_a(sign_a), .sign_b(sign_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_zero(flag_zero)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Reference: signed-magnitude arithmetic, normalised by repeated halving/doubling.
    function automatic logic [34:0] model(input logic [23:0] ma, input logic [23:0] mb,
                                          input logic [7:0] e, input logic sa, input logic sb);
        int unsigned m;
        int ex;
        logic s;
        if (sa == sb) begin m = ma + mb; s = sa; end
        else if (ma >= mb) begin m = ma - mb; s = sa; end
        else begin m = mb - ma; s = sb; end
        ex = e;
        if (m == 0) return {32'h0, 3'b001};
        while (m >= (1 << 24)) begin m = m >> 1; ex++; end
        while (m < (1 << 23)) begin m = m << 1; ex--; end
        if (ex >= 255) return {s, 8'hFF, 23'h0, 3'b100};
        if (ex <= 0) return {s, 31'h0, 3'b010};
        return {s, ex[7:0], m[22:0], 3'b000};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send(input logic [23:0] ma, input logic [23:0] mb, input logic [7:0] e,
                        input logic sa, input logic sb, input logic [34:0] ev);
        int n = 0;
        mant_a = ma; mant_b = mb; exp_large = e; sign_a = sa; sign_b = sb;
        in_valid = 1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 50) begin
                checks++; errors++;
                $display("FAIL send_timeout in_ready stuck at 0, required 1");
                in_valid = 0;
                return;
            end
        end
        exp_q.push_back(ev);
        accepted++;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic send_rand();
        logic [23:0] a, b, t;
        logic [7:0] e;
        logic sa, sb;
        int r;
        a = {1'b1, 23'($urandom)};
        b = {1'b1, 23'($urandom)} >> $urandom_range(0, 24);
        if ($urandom_range(0, 15) == 0) b = a;
        if ($urandom_range(0, 1) == 1) begin t = a; a = b; b = t; end
        r = $urandom_range(0, 9);
        e = (r == 0) ? 8'($urandom_range(248, 255)) :
            (r == 1) ? 8'($urandom_range(0, 24)) : 8'($urandom_range(1, 254));
        sa = 1'($urandom); sb = 1'($urandom);
        send(a, b, e, sa, sb, model(a, b, e, sa, sb));
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 0);
    endtask

    initial begin
        out_ready = 0;
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: hold-stability under stall, then pop-and-compare on each output transfer.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 0;
            continue;
        end
        if (prev_stall)
            chk("hold_stable", {out_valid, result, flag_ovf, flag_unf, flag_zero}, {1'b1, prev_out});
        prev_stall = out_valid && !out_ready;
        prev_out   = {result, flag_ovf, flag_unf, flag_zero};
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output result=%h with no pending entry", result);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result_flags", {result, flag_ovf, flag_unf, flag_zero}, mon_e);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; in_valid = 0;
        mant_a = 0; mant_b = 0; exp_large = 0; sign_a = 0; sign_b = 0;
        repeat (2) @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {flag_ovf, flag_unf, flag_zero}, 0);
        rst_n = 1; #1;
        chk("rst_in_ready", in_ready, 1);
        out_ready = 1;
        @(posedge clk); #1;

        send(24'h800000, 24'h800000, 8'd127, 0, 0, {32'h40000000, 3'b000});
        chk("latency_c1", out_valid, 0);
        @(posedge clk); #1;
        chk("latency_c2", out_valid, 1);
        send(24'h800000, 24'h800000, 8'd127, 0, 1, {32'h00000000, 3'b001});
        send(24'h800000, 24'hC00000, 8'd127, 0, 1, {32'hBF000000, 3'b000});
        send(24'h800000, 24'h800000, 8'd254, 0, 0, {32'h7F800000, 3'b100});
        send(24'h800000, 24'h7FFFFF, 8'd1, 0, 1, {32'h00000000, 3'b010});
        send(24'h000000, 24'h000000, 8'd0, 0, 0, {32'h00000000, 3'b001});
        send(24'h800000, 24'h800000, 8'd200, 1, 1, {32'hE4800000, 3'b000});
        drain();

        out_ready = 0; accepted = 0;
        fork
            begin
                send(24'h800000, 24'h800000, 8'd127, 0, 0, {32'h40000000, 3'b000});
                send(24'h800000, 24'hC00000, 8'd127, 0, 1, {32'hBF000000, 3'b000});
                send(24'hC00000, 24'h400000, 8'd130, 1, 1, {32'hC1800000, 3'b000});
            end
            begin
                repeat (6) @(posedge clk); #2;
                chk("bp_accepted", 64'(accepted), 2);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                out_ready = 1;
            end
        join
        drain();

        rand_rdy = 1;
        for (int i = 0; i < 300; i++) send_rand();
        rand_rdy = 0;
        #1 out_ready = 1;
        drain();

        send(24'h800000, 24'h800000, 8'd127, 0, 0, {32'h40000000, 3'b000});
        send(24'h800000, 24'h800000, 8'd128, 0, 0, {32'h40800000, 3'b000});
        rst_n = 0; #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_result", result, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1;
        repeat (10) @(posedge clk); #1;
        chk("post_rst_idle", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
